// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract sequencing controller.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int ID_W = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the loser after each grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr;

    // Grant a lone requester directly; on contention the pointer decides.
    always_comb begin
        grant = '0;
        if (en) begin
            if (req == 2'b01)
                grant = 2'b01;
            else if (req == 2'b10)
                grant = 2'b10;
            else if (req == 2'b11)
                grant = ptr ? 2'b10 : 2'b01;
        end
    end

    // A grant is always an accept, so the pointer follows it directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (grant[0])
            ptr <= 1'b1;
        else if (grant[1])
            ptr <= 1'b0;
    end

endmodule

// File: rtl/addsub_arbiter_ctrl.sv
// Shares one external ripple-carry adder between two requesters: captures
// operands, waits for the carry to settle, then returns a tagged result.
module addsub_arbiter_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic [ID_W-1:0]  rsp_id,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_cin,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic             adder_cout
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   id_q;
    logic [1:0]        grant;
    logic              arb_en;
    logic              sel_op;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic              ovf_now;

    // Readys are forced low while reset is asserted, even though state is IDLE.
    assign arb_en = (state == IDLE) && rst_n;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Route the granted requester's operation towards the capture registers.
    always_comb begin
        sel_op = req0_op;
        sel_a  = req0_a;
        sel_b  = req0_b;
        if (grant[1]) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
        end
    end

    // Overflow: operands of equal sign produced a sum of the other sign.
    always_comb begin
        ovf_now = (adder_a[WIDTH-1] == adder_b[WIDTH-1]) &&
                  (adder_sum[WIDTH-1] != adder_a[WIDTH-1]);
    end

    // Sequencer: capture on accept, count out the settle time, hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            id_q       <= '0;
            adder_a    <= '0;
            adder_b    <= '0;
            adder_cin  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_id     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        adder_a   <= sel_a;
                        adder_b   <= (sel_op == OP_SUB) ? ~sel_b : sel_b;
                        adder_cin <= sel_op;
                        id_q      <= grant[1];
                        cnt       <= CNT_W'(SETTLE_CYCLES - 1);
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rsp_result <= adder_sum;
                        rsp_cout   <= adder_cout;
                        rsp_ovf    <= ovf_now;
                        rsp_id     <= id_q;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter_ctrl.sv
// Scoreboard bench: accepts are predicted from the arbitration rules and
// queued with arithmetic results; a monitor pops and compares each response.
module tb_addsub_arbiter_ctrl;

    localparam int W = 32;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid, req0_ready, req0_op;
    logic [W-1:0]  req0_a, req0_b;
    logic          req1_valid, req1_ready, req1_op;
    logic [W-1:0]  req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_cout, rsp_ovf;
    logic          rsp_id;
    logic [W-1:0]  rsp_result;
    logic [W-1:0]  adder_a, adder_b, adder_sum;
    logic          adder_cin, adder_cout;

    always #5 clk = ~clk;

    // Behavioural external adder.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {{W{1'b0}}, adder_cin};

    addsub_arbiter_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_id(rsp_id),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_sum(adder_sum), .adder_cout(adder_cout)
    );

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         id;
        int           t;
    } exp_t;

    exp_t   sbq[$];
    exp_t   ex;
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    bit     busy = 0;
    bit     pri = 0;
    bit     e0, e1;
    logic   pv = 0, pr = 0;
    logic [W-1:0] h_r;
    logic   h_c, h_o, h_id;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // Result of A op B computed with wide unsigned and signed arithmetic.
    function automatic exp_t model(bit id, bit op, logic [W-1:0] a, logic [W-1:0] b, int t);
        exp_t e;
        longint sa, sb, sr, hi, lo;
        logic [63:0] wide;
        sa = $signed(a);
        sb = $signed(b);
        hi = (longint'(1) <<< (W - 1)) - 1;
        lo = -(longint'(1) <<< (W - 1));
        wide = {32'b0, a} + {32'b0, b};
        e.r  = op ? a - b : a + b;
        e.c  = op ? (a >= b) : (wide[W] == 1'b1);
        sr   = op ? sa - sb : sa + sb;
        e.o  = (sr > hi) || (sr < lo);
        e.id = id;
        e.t  = t;
        return e;
    endfunction

    // Monitor: predicts readys, queues accepted work, checks responses.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            busy = 0;
            pri  = 0;
            pv   = 0;
            pr   = 0;
        end else begin
            e0 = !busy && req0_valid && (!req1_valid || pri == 1'b0);
            e1 = !busy && req1_valid && (!req0_valid || pri == 1'b1);
            chk("req0_ready", {63'b0, req0_ready}, {63'b0, e0});
            chk("req1_ready", {63'b0, req1_ready}, {63'b0, e1});
            if (e0) begin
                sbq.push_back(model(1'b0, req0_op, req0_a, req0_b, cyc + 1));
                busy = 1;
                pri  = 1;
            end else if (e1) begin
                sbq.push_back(model(1'b1, req1_op, req1_a, req1_b, cyc + 1));
                busy = 1;
                pri  = 0;
            end
            if (rsp_valid && !pv) begin
                if (sbq.size() == 0) begin
                    fail_now("unexpected_response");
                end else begin
                    ex = sbq.pop_front();
                    chk("rsp_result", {32'b0, rsp_result}, {32'b0, ex.r});
                    chk("rsp_cout", {63'b0, rsp_cout}, {63'b0, ex.c});
                    chk("rsp_ovf", {63'b0, rsp_ovf}, {63'b0, ex.o});
                    chk("rsp_id", {63'b0, rsp_id}, {63'b0, ex.id});
                    chk("latency", 64'(cyc - ex.t), 64'(S));
                end
            end
            if (rsp_valid && pv && !pr) begin
                chk("hold_result", {32'b0, rsp_result}, {32'b0, h_r});
                chk("hold_cout", {63'b0, rsp_cout}, {63'b0, h_c});
                chk("hold_ovf", {63'b0, rsp_ovf}, {63'b0, h_o});
                chk("hold_id", {63'b0, rsp_id}, {63'b0, h_id});
            end
            if (rsp_valid && rsp_ready) busy = 0;
            pv   = rsp_valid;
            pr   = rsp_ready;
            h_r  = rsp_result;
            h_c  = rsp_cout;
            h_o  = rsp_ovf;
            h_id = rsp_id;
        end
    end

    task automatic drive_one(input bit id, input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        if (id == 1'b0) begin
            req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
        end
        t = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_now(id ? "accept1" : "accept0");
        else begin
            @(posedge clk);
            #1;
        end
        if (id == 1'b0) req0_valid = 0;
        else req1_valid = 0;
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_many(input bit id, input int n);
        for (int i = 0; i < n; i++)
            drive_one(id, 1'($urandom_range(0, 1)), rand_opnd(), rand_opnd());
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sbq.size() != 0 || rsp_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) fail_now("wait_idle");
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req0_ready"}, {63'b0, req0_ready}, 64'd0);
        chk({tag, "_req1_ready"}, {63'b0, req1_ready}, 64'd0);
        chk({tag, "_rsp_valid"}, {63'b0, rsp_valid}, 64'd0);
        chk({tag, "_rsp_result"}, {32'b0, rsp_result}, 64'd0);
        chk({tag, "_rsp_flags"}, {61'b0, rsp_cout, rsp_ovf, rsp_id}, 64'd0);
        chk({tag, "_adder_a"}, {32'b0, adder_a}, 64'd0);
        chk({tag, "_adder_b"}, {32'b0, adder_b}, 64'd0);
        chk({tag, "_adder_cin"}, {63'b0, adder_cin}, 64'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        req0_valid = 0; req0_op = 0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_op = 0; req1_a = '0; req1_b = '0;
        rsp_ready  = 1;
        #2;
        chk_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;

        // Directed arithmetic cases
        drive_one(1'b0, 1'b0, 32'd5, 32'd3);               wait_idle();
        drive_one(1'b1, 1'b1, 32'd3, 32'd5);               wait_idle();
        drive_one(1'b1, 1'b1, 32'd5, 32'd3);               wait_idle();
        drive_one(1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1);       wait_idle();
        drive_one(1'b0, 1'b1, 32'h8000_0000, 32'd1);       wait_idle();

        // Contention straight out of reset
        pulse_reset();
        fork
            drive_many(1'b0, 4);
            drive_many(1'b1, 4);
        join
        wait_idle();

        // Backpressure with both requesters waiting
        rsp_ready = 0;
        fork
            drive_many(1'b0, 2);
            drive_many(1'b1, 2);
            begin
                repeat (12) @(posedge clk);
                #1;
                rsp_ready = 1;
            end
        join
        wait_idle();

        // Random traffic with random response backpressure
        fork
            drive_many(1'b0, 8);
            drive_many(1'b1, 8);
            begin
                repeat (80) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
                rsp_ready = 1;
            end
        join
        wait_idle();

        // Reset while an operation is settling
        drive_one(1'b0, 1'b0, 32'd100, 32'd23);
        rst_n = 0;
        req0_valid = 1; req0_op = 0; req0_a = 32'd9; req0_b = 32'd4;
        req1_valid = 1; req1_op = 1; req1_a = 32'd9; req1_b = 32'd4;
        #1;
        chk_zero("midreset");
        @(posedge clk);
        #1;
        rst_n = 1;
        fork
            drive_one(1'b0, 1'b0, 32'd9, 32'd4);
            drive_one(1'b1, 1'b1, 32'd9, 32'd4);
        join
        wait_idle();
        repeat (5) @(posedge clk);
        #1;

        chk("queue_empty", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
